// File: rtl/updown_count_ctrl.sv
// Sequencer for a WIDTH-bit up/down counter: prescales CLOCK_50 into count
// ticks, synchronises the direction switch and issues step/load strobes.
module updown_count_ctrl #(
  parameter int WIDTH       = 4,
  parameter int TICK_DIV    = 50000000,
  parameter int SYNC_STAGES = 2
) (
  input  logic             CLOCK_50,
  input  logic             resetn,
  input  logic             dir_sw,
  input  logic             run,
  input  logic             sat_mode,
  input  logic             load_req,
  input  logic [WIDTH-1:0] load_value,
  input  logic [WIDTH-1:0] count,
  output logic             cnt_en,
  output logic             cnt_up,
  output logic             cnt_load,
  output logic [WIDTH-1:0] cnt_load_val,
  output logic             tick,
  output logic [1:0]       state,
  output logic             at_limit
);

  localparam int                 DIV_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [DIV_W-1:0]   DIV_LAST = DIV_W'(TICK_DIV - 1);
  localparam logic [WIDTH-1:0]   CNT_MAX  = '1;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    LOAD = 2'b10
  } state_t;

  state_t                 state_q, state_d;
  logic [DIV_W-1:0]       div_cnt;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   dir_s;
  logic                   wrap;
  logic                   step;
  logic                   load_accept;
  logic                   lim_new_dir;

  assign dir_s       = sync_q[SYNC_STAGES-1];
  assign wrap        = (state_q == RUN) && (div_cnt == DIV_LAST);
  assign lim_new_dir = dir_s ? (count == CNT_MAX) : (count == '0);
  assign state       = state_q;

  // NOTE: every sequential block uses non-blocking (<=) assignments so all
  // flops sample the same pre-edge values regardless of block ordering.
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      sync_q  <= '0;
      state_q <= IDLE;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], dir_sw};
      state_q <= state_d;
    end
  end

  // Priority load_req > run > tick; LOAD always lasts a single cycle.
  // NOTE: every always_comb output gets a default first, so no path
  // through the case can leave a value unassigned and infer a latch.
  always_comb begin
    state_d     = state_q;
    load_accept = 1'b0;
    step        = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (load_req) begin
          state_d     = LOAD;
          load_accept = 1'b1;
        end else if (run) begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (load_req) begin
          state_d     = LOAD;
          load_accept = 1'b1;
        end else if (!run) begin
          state_d = IDLE;
        end else begin
          step = wrap;
        end
      end
      LOAD:    state_d = run ? RUN : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Prescaler only runs while staying in RUN; any exit clears it.
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      div_cnt <= '0;
    end else if (state_q == RUN && state_d == RUN) begin
      div_cnt <= wrap ? '0 : div_cnt + DIV_W'(1);
    end else begin
      div_cnt <= '0;
    end
  end

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      cnt_en       <= 1'b0;
      cnt_up       <= 1'b1;
      cnt_load     <= 1'b0;
      cnt_load_val <= '0;
      tick         <= 1'b0;
      at_limit     <= 1'b0;
    end else begin
      tick     <= step;
      cnt_en   <= step && !(sat_mode && lim_new_dir);
      cnt_load <= load_accept;
      at_limit <= sat_mode && (cnt_up ? (count == CNT_MAX) : (count == '0));
      if (step) begin
        cnt_up <= dir_s;
      end
      if (load_accept) begin
        cnt_load_val <= load_value;
      end
    end
  end

endmodule

// File: tb/tb_updown_count_ctrl.sv
// Directed bench for updown_count_ctrl: expectations are queued per cycle and
// compared against the sampled outputs 1 ns after each rising edge.
module tb_updown_count_ctrl;

  localparam int W = 4;

  localparam logic [1:0] S_IDLE = 2'b00;
  localparam logic [1:0] S_RUN  = 2'b01;
  localparam logic [1:0] S_LOAD = 2'b10;

  // Output vector layout: {state[1:0], tick, cnt_en, cnt_up, cnt_load, cnt_load_val[3:0], at_limit}
  localparam logic [10:0] M_S   = 11'h600;
  localparam logic [10:0] M_T   = 11'h100;
  localparam logic [10:0] M_E   = 11'h080;
  localparam logic [10:0] M_U   = 11'h040;
  localparam logic [10:0] M_L   = 11'h020;
  localparam logic [10:0] M_V   = 11'h01E;
  localparam logic [10:0] M_ALL = 11'h7FF;
  localparam logic [10:0] M_NV  = 11'h7E1;
  localparam logic [10:0] RST_V = 11'b00_0_0_1_0_0000_0;

  logic           CLOCK_50 = 1'b0;
  logic           resetn   = 1'b0;
  logic           dir_sw   = 1'b1;
  logic           run      = 1'b0;
  logic           sat_mode = 1'b0;
  logic           load_req = 1'b0;
  logic [W-1:0]   load_value = '0;
  logic [W-1:0]   count      = '0;
  logic           cnt_en, cnt_up, cnt_load, tick, at_limit;
  logic [W-1:0]   cnt_load_val;
  logic [1:0]     state;
  logic [10:0]    obs;

  typedef struct {
    int unsigned at;
    string       tag;
    logic [10:0] exp;
    logic [10:0] mask;
  } exp_t;

  exp_t        sb[$];
  int unsigned cyc_n = 0;
  int          total = 0;
  int          bad   = 0;

  updown_count_ctrl #(.WIDTH(W), .TICK_DIV(4), .SYNC_STAGES(2)) dut (
    .CLOCK_50    (CLOCK_50),
    .resetn      (resetn),
    .dir_sw      (dir_sw),
    .run         (run),
    .sat_mode    (sat_mode),
    .load_req    (load_req),
    .load_value  (load_value),
    .count       (count),
    .cnt_en      (cnt_en),
    .cnt_up      (cnt_up),
    .cnt_load    (cnt_load),
    .cnt_load_val(cnt_load_val),
    .tick        (tick),
    .state       (state),
    .at_limit    (at_limit)
  );

  assign obs = {state, tick, cnt_en, cnt_up, cnt_load, cnt_load_val, at_limit};

  always #5 CLOCK_50 = ~CLOCK_50;

  function automatic logic [10:0] ov(logic [1:0] st, logic tk, logic en, logic up,
                                     logic ld, logic [3:0] v, logic lim);
    return {st, tk, en, up, ld, v, lim};
  endfunction

  task automatic push(input string tag, input int unsigned at,
                      input logic [10:0] e, input logic [10:0] m);
    exp_t x;
    x.at   = at;
    x.tag  = tag;
    x.exp  = e;
    x.mask = m;
    sb.push_back(x);
  endtask

  task automatic drain();
    exp_t x;
    while (sb.size() > 0 && sb[0].at <= cyc_n) begin
      x = sb.pop_front();
      total++;
      assert ((obs & x.mask) === (x.exp & x.mask)) else begin
        bad++;
        $error("FAIL %s @cyc %0d: got %h want %h (mask %h)",
               x.tag, cyc_n, obs & x.mask, x.exp & x.mask, x.mask);
      end
    end
  endtask

  task automatic cyc();
    @(posedge CLOCK_50);
    #1;
    cyc_n++;
    drain();
  endtask

  task automatic expect_next(input string tag, input logic [10:0] e, input logic [10:0] m);
    push(tag, cyc_n + 1, e, m);
    cyc();
  endtask

  task automatic check_now(input string tag, input logic [10:0] e, input logic [10:0] m);
    push(tag, cyc_n, e, m);
    drain();
  endtask

  // Three non-tick cycles of a prescaler period; optionally flips dir_sw after cycle flip_at.
  task automatic pre_wrap(input string tag, input logic up, input logic lim, input int flip_at);
    for (int i = 0; i < 3; i++) begin
      expect_next(tag, ov(S_RUN, 1'b0, 1'b0, up, 1'b0, 4'h0, lim), M_NV);
      if (i == flip_at) dir_sw = ~dir_sw;
    end
  endtask

  // One full prescaler period ending in a tick; the bench's counter follows cnt_en.
  task automatic tick_period(input string tag, input logic en, input logic up_old,
                             input logic up_new, input logic lim, input int flip_at);
    pre_wrap(tag, up_old, lim, flip_at);
    expect_next({tag, "_tick"}, ov(S_RUN, 1'b1, en, up_new, 1'b0, 4'h0, lim), M_NV);
    if (en) count = up_new ? count + 4'd1 : count - 4'd1;
  endtask

  task automatic do_load(input string tag, input logic [3:0] val, input logic up,
                         input logic lim_new);
    load_req   = 1'b1;
    load_value = val;
    expect_next({tag, "_ld"}, ov(S_LOAD, 1'b0, 1'b0, up, 1'b1, val, 1'b0),
                M_S | M_E | M_U | M_L | M_V);
    load_req   = 1'b0;
    load_value = ~val;
    count      = val;
    expect_next({tag, "_ret"}, ov(S_RUN, 1'b0, 1'b0, up, 1'b0, val, lim_new), M_ALL);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset held across edges, then released with run=0.
    cyc();
    cyc();
    check_now("reset", RST_V, M_ALL);
    resetn = 1'b1;
    for (int i = 0; i < 20; i++) expect_next("idle", RST_V, M_ALL);

    // Wrap-mode up count from 0: 17 ticks cover the 15 -> 0 wrap.
    run = 1'b1;
    expect_next("enter_run", ov(S_RUN, 1'b0, 1'b0, 1'b1, 1'b0, 4'h0, 1'b0), M_ALL);
    for (int i = 0; i < 17; i++) tick_period("up", 1'b1, 1'b1, 1'b1, 1'b0, -1);

    // Saturate at max while counting up.
    sat_mode = 1'b1;
    count    = 4'd15;
    tick_period("sat_up", 1'b0, 1'b1, 1'b1, 1'b1, -1);
    tick_period("sat_up", 1'b0, 1'b1, 1'b1, 1'b1, -1);

    // Load 7 mid-interval releases the limit.
    do_load("load7", 4'd7, 1'b1, 1'b0);
    tick_period("resume", 1'b1, 1'b1, 1'b1, 1'b0, -1);

    // dir_sw drops two edges before a tick: too late for that tick, seen on the next.
    tick_period("dir_late", 1'b1, 1'b1, 1'b1, 1'b0, 1);
    tick_period("dir_new", 1'b1, 1'b1, 1'b0, 1'b0, -1);
    tick_period("down", 1'b1, 1'b0, 1'b0, 1'b0, -1);

    // Saturate at zero while counting down.
    count = 4'd0;
    tick_period("sat_dn", 1'b0, 1'b0, 1'b0, 1'b1, -1);
    tick_period("sat_dn", 1'b0, 1'b0, 1'b0, 1'b1, -1);

    // Load request on the prescaler-wrap cycle wins over the step.
    pre_wrap("pre_ld9", 1'b0, 1'b1, -1);
    do_load("load9", 4'd9, 1'b0, 1'b0);
    tick_period("after_ld9", 1'b1, 1'b0, 1'b0, 1'b0, -1);

    // Asynchronous reset during the LOAD cycle.
    load_req   = 1'b1;
    load_value = 4'd5;
    expect_next("ld5", ov(S_LOAD, 1'b0, 1'b0, 1'b0, 1'b1, 4'd5, 1'b0),
                M_S | M_E | M_L | M_V);
    resetn = 1'b0;
    #1;
    check_now("rst_in_load", RST_V, M_ALL);
    load_req = 1'b0;
    run      = 1'b0;
    sat_mode = 1'b0;
    expect_next("rst_hold", RST_V, M_ALL);
    resetn = 1'b1;
    for (int i = 0; i < 3; i++) expect_next("post_rst", RST_V, M_ALL);

    total++;
    assert (sb.size() == 0) else begin
      bad++;
      $error("FAIL sb_empty: got %0d entries left want 0", sb.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/updown_count_ctrl.md
Name: updown_count_ctrl

Overview:
Sequencer for the board-level WIDTH-bit up/down counter datapath.
- Divides CLOCK_50 into a count tick.
- Synchronises the direction switch and applies direction changes only on tick boundaries.
- Issues single-cycle count-enable and load strobes to the counter.
- Enforces wrap or saturate policy using the counter's current value, which is fed back.
- Sits between board inputs (SW/KEY-derived) and the counter register; state and tick are exported for LEDR/GPIO debug.

Parameters:
WIDTH, 4, counter width; max value = 2^WIDTH-1
TICK_DIV, 50000000, CLOCK_50 cycles per count tick; minimum 2 (benches use 4)
SYNC_STAGES, 2, flops in the dir_sw synchroniser; minimum 2

Ports:
CLOCK_50  in  1  system clock, 50 MHz
resetn  in  1  asynchronous active-low reset (driven from KEY[0])
dir_sw  in  1  asynchronous direction switch; 1 = up, 0 = down
run  in  1  synchronous level; 1 = counting enabled
sat_mode  in  1  synchronous level; 1 = saturate at 0/max, 0 = wrap
load_req  in  1  synchronous single-cycle load request
load_value  in  WIDTH  value to load; sampled when load_req=1
count  in  WIDTH  current counter value (feedback)
cnt_en  out  1  one-cycle step strobe to counter
cnt_up  out  1  direction to counter; 1 = increment
cnt_load  out  1  one-cycle load strobe to counter
cnt_load_val  out  WIDTH  value to load, valid while cnt_load=1
tick  out  1  one-cycle prescaler tick (debug)
state  out  2  FSM state: 00 IDLE, 01 RUN, 10 LOAD
at_limit  out  1  registered; saturation limit reached in current direction

Behaviour:
- Reset (resetn=0, async): all flops clear immediately. Output values: cnt_en=0, cnt_up=1, cnt_load=0, cnt_load_val=0, tick=0, state=IDLE, at_limit=0. Prescaler=0; synchroniser flops=0.
- All outputs are registered; no combinational input-to-output paths.
- Synchroniser: dir_s = dir_sw delayed SYNC_STAGES cycles. run, sat_mode and load_req are used directly.
- Prescaler (div_cnt):
  - Counts only in RUN; held at 0 in IDLE and LOAD.
  - In RUN, increments each cycle. When div_cnt == TICK_DIV-1, it returns to 0 and tick=1 the next cycle.
  - First tick appears TICK_DIV cycles after entering RUN.
- FSM, transition priority load_req > run > tick:
  - IDLE: load_req=1 -> LOAD; else run=1 -> RUN; else stay.
  - RUN: load_req=1 -> LOAD; else run=0 -> IDLE; else stay and service ticks.
  - LOAD: lasts exactly one cycle. Next state is RUN if run=1, else IDLE. load_req in LOAD is ignored.
- Load: on the cycle load_req=1 is accepted, cnt_load_val<=load_value and the state moves to LOAD. cnt_load=1 for exactly the LOAD cycle. cnt_load_val holds its value afterwards.
- Step (on a prescaler wrap in RUN, no load_req, run=1):
  - cnt_up<=dir_s.
  - cnt_en<=1 unless sat_mode=1 and the counter is at its limit for the new direction. Limit means count == 2^WIDTH-1 when dir_s=1, or count == 0 when dir_s=0. At the limit, cnt_en<=0.
  - cnt_en is high for exactly one cycle, aligned with tick.
  - The counter updates on the cycle after cnt_en.
- Direction changes between ticks are not visible on cnt_up until the next tick.
- Wrap mode (sat_mode=0): cnt_en is always issued on a tick; the counter performs the modular wrap.
- at_limit: registered each cycle as sat_mode && ((cnt_up && count==max) || (!cnt_up && count==0)).
- Simultaneous tick and load_req: load wins; no cnt_en that cycle; prescaler clears.
- run deasserted on a tick cycle: no cnt_en; go to IDLE.
- cnt_en and cnt_load are never high together.
- Reset asserted mid-operation (including during LOAD): outputs go to reset values asynchronously; any pending strobe is dropped.

Test Plan:
- Reset then idle (TICK_DIV=4, resetn 0->1, run=0, 20 cycles) -> state=00, cnt_en never high, cnt_up=1, tick never high.
- Up count (run=1, dir_sw=1, sat_mode=0, count=0) -> first tick/cnt_en 4 cycles after entering RUN, then every 4 cycles; cnt_up=1; count steps 0,1,2,... and wraps 15->0 with cnt_en still issued.
- Direction sync (toggle dir_sw to 0 mid-interval) -> cnt_up stays 1 until the first tick at least SYNC_STAGES cycles after the toggle, then 0; no glitch on cnt_en.
- Saturation (sat_mode=1, dir up, count=15; then dir down, count=0) -> cnt_en stays 0 on ticks and at_limit=1; after load 7, cnt_en resumes and at_limit=0.
- Load priority (load_req=1, load_value=9 on a prescaler-wrap cycle) -> state=10 for 1 cycle, cnt_load=1, cnt_load_val=9, no cnt_en that cycle; returns to RUN; next tick 4 cycles later.
- Async reset mid-LOAD (resetn low during the LOAD cycle) -> cnt_load drops to 0 and state=00 immediately, without waiting for a clock edge; all outputs at reset values.
